// File: rtl/vga_stream_pkg.sv
// Shared types and constants for 640x480 30-bit RGB Avalon-ST pixel streams.
// Pixels are packed {R[29:20], G[19:10], B[9:0]}, 10 bits per channel.
package vga_stream_pkg;

    localparam int VGA_WIDTH  = 640;
    localparam int VGA_HEIGHT = 480;

    localparam logic [29:0] RGB10_RED   = 30'h3FF00000;
    localparam logic [29:0] RGB10_GREEN = 30'h000FFC00;

    typedef struct packed {
        logic [29:0] data;
        logic        sop;
        logic        eop;
    } pixel_beat_t;

    // Per-channel (a>>1)+(b>>1); each half is at most 511, so the sum never overflows 10 bits.
    function automatic logic [29:0] rgb10_blend50(input logic [29:0] a, input logic [29:0] b);
        logic [29:0] r;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            r[c*10 +: 10] = {1'b0, a[c*10+1 +: 9]} + {1'b0, b[c*10+1 +: 9]};
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_st_skid.sv
// Generic two-register Avalon-ST skid buffer for pixel_beat_t.
// Main output register plus one skid register; o_ready depends only on
// skid occupancy, so the upstream ready path is fully registered.
module vga_st_skid
    import vga_stream_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  pixel_beat_t i_beat,
    input  logic        i_valid,
    output logic        o_ready,
    output pixel_beat_t o_beat,
    output logic        o_valid,
    input  logic        i_ready
);

    logic        r_out_valid;
    pixel_beat_t r_out_beat;
    logic        r_skid_valid;
    pixel_beat_t r_skid_beat;

    logic w_in_fire;
    logic w_out_free;

    // Ready is held low during reset so nothing is accepted into a clearing pipe.
    assign o_ready    = ~r_skid_valid & ~i_rst;
    assign w_in_fire  = i_valid & o_ready;
    assign w_out_free = ~r_out_valid | i_ready;

    // Refill the output register from the skid first, otherwise from the input;
    // park the input in the skid when the output is stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_valid  <= 1'b0;
            r_out_beat   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_beat  <= '0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out_beat   <= r_skid_beat;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_out_beat <= i_beat;
                end
            end
        end else if (w_in_fire) begin
            r_skid_beat  <= i_beat;
            r_skid_valid <= 1'b1;
        end
    end

    assign o_beat  = r_out_beat;
    assign o_valid = r_out_valid;

endmodule

// File: rtl/vga_bpm_bar_overlay.sv
// BPM bar-graph overlay stage for the VGA pixel stream.
// Tracks raster position from sop/eop, latches BPM and enable at each sop,
// paints a horizontal bar (green <= threshold, red above) and flags framing errors.
// Build option: define VGA_BPM_BAR_BLEND_EN to blend the bar 50% with the
// underlying pixel instead of drawing it opaque.
module vga_bpm_bar_overlay
    import vga_stream_pkg::*;
#(
    parameter int WIDTH       = VGA_WIDTH,
    parameter int HEIGHT      = VGA_HEIGHT,
    parameter int BAR_X0      = 20,
    parameter int BAR_Y0      = 8,
    parameter int BAR_H       = 16,
    parameter int PX_PER_BPM  = 3,
    parameter int BAR_MAX_BPM = 200,
    parameter int THRESH_BPM  = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] final_bpm_estimate,
    input  logic        overlay_en,
    input  logic [29:0] in_data,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [29:0] out_data,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sync_err
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);

    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] X_ONE   = XW'(1);
    localparam logic [YW-1:0] Y_ONE   = YW'(1);
    localparam logic [YW-1:0] BAR_YS  = YW'(BAR_Y0);
    localparam logic [YW-1:0] BAR_YE  = YW'(BAR_Y0 + BAR_H);
    localparam logic [15:0]   BAR_XS  = 16'(BAR_X0);
    localparam logic [15:0]   BPM_MAX = 16'(BAR_MAX_BPM);
    localparam logic [15:0]   BPM_THR = 16'(THRESH_BPM);
    localparam logic [15:0]   PX_MUL  = 16'(PX_PER_BPM);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [15:0]   r_bpm_frame;
    logic          r_en_frame;
    logic          r_sync_err;

    logic          w_in_fire;
    logic [XW-1:0] w_px;
    logic [YW-1:0] w_py;
    logic [15:0]   w_bpm;
    logic          w_en;
    logic          w_at_origin;
    logic          w_at_last;
    logic          w_frame_err;
    logic [15:0]   w_bpm_clamp;
    logic [15:0]   w_len;
    logic [15:0]   w_x_end;
    logic          w_hit;
    logic [29:0]   w_bar_colour;
    logic [29:0]   w_pix;

    pixel_beat_t   w_in_beat;
    pixel_beat_t   w_out_beat;

    assign w_in_fire = in_valid & in_ready;

    // An sop beat is always (0,0) and uses the BPM/enable being latched on it.
    assign w_px  = in_startofpacket ? '0 : r_x;
    assign w_py  = in_startofpacket ? '0 : r_y;
    assign w_bpm = in_startofpacket ? final_bpm_estimate : r_bpm_frame;
    assign w_en  = in_startofpacket ? overlay_en : r_en_frame;

    assign w_at_origin = (r_x == '0) && (r_y == '0);
    assign w_at_last   = (w_px == X_LAST) && (w_py == Y_LAST);
    assign w_frame_err = (in_startofpacket & ~w_at_origin)
                       | (in_endofpacket & ~w_at_last)
                       | (w_at_last & ~in_endofpacket);

    assign w_bpm_clamp = (w_bpm > BPM_MAX) ? BPM_MAX : w_bpm;
    assign w_len       = w_bpm_clamp * PX_MUL;
    assign w_x_end     = BAR_XS + w_len;
    assign w_hit       = w_en
                       && (w_py >= BAR_YS) && (w_py < BAR_YE)
                       && (16'(w_px) >= BAR_XS) && (16'(w_px) < w_x_end);

    // Select the bar colour and substitute it for pixels that fall inside the bar.
    always_comb begin
        w_bar_colour = (w_bpm > BPM_THR) ? RGB10_RED : RGB10_GREEN;
        w_pix        = in_data;
        if (w_hit) begin
`ifdef VGA_BPM_BAR_BLEND_EN
            w_pix = rgb10_blend50(w_bar_colour, in_data);
`else
            w_pix = w_bar_colour;
`endif
        end
    end

    // Raster tracking, per-frame latches and the sticky framing-error flag.
    // Counters resynchronise to (0,0) after eop or the last pixel either way.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_bpm_frame <= '0;
            r_en_frame  <= 1'b0;
            r_sync_err  <= 1'b0;
        end else if (w_in_fire) begin
            if (in_startofpacket) begin
                r_bpm_frame <= final_bpm_estimate;
                r_en_frame  <= overlay_en;
            end
            if (w_frame_err) begin
                r_sync_err <= 1'b1;
            end
            if (in_endofpacket || w_at_last) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_px == X_LAST) begin
                r_x <= '0;
                r_y <= w_py + Y_ONE;
            end else begin
                r_x <= w_px + X_ONE;
                r_y <= w_py;
            end
        end
    end

    assign w_in_beat.data = w_pix;
    assign w_in_beat.sop  = in_startofpacket;
    assign w_in_beat.eop  = in_endofpacket;

    vga_st_skid u_skid (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_beat  (w_in_beat),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .o_beat  (w_out_beat),
        .o_valid (out_valid),
        .i_ready (out_ready)
    );

    assign out_data          = w_out_beat.data;
    assign out_startofpacket = w_out_beat.sop;
    assign out_endofpacket   = w_out_beat.eop;
    assign sync_err          = r_sync_err;

endmodule

// File: tb/tb_vga_bpm_bar_overlay.sv
// Self-checking bench for vga_bpm_bar_overlay, run on a reduced 224x25 raster
// with the bar clamp lowered to 60 BPM (180 px) so clamping stays visible.
`timescale 1ns/1ps
module tb_vga_bpm_bar_overlay;

    localparam int W    = 224;
    localparam int H    = 25;
    localparam int N    = W * H;
    localparam int BX0  = 20;
    localparam int BY0  = 8;
    localparam int BH   = 16;
    localparam int PXB  = 3;
    localparam int BMAX = 60;
    localparam int THR  = 120;
    localparam logic [29:0] RED_L   = 30'h3FF00000;
    localparam logic [29:0] GREEN_L = 30'h000FFC00;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] final_bpm_estimate;
    logic        overlay_en;
    logic [29:0] in_data;
    logic        in_sop, in_eop, in_valid, in_ready;
    logic [29:0] out_data;
    logic        out_sop, out_eop, out_valid, out_ready;
    logic        sync_err;

    vga_bpm_bar_overlay #(
        .WIDTH(W), .HEIGHT(H), .BAR_X0(BX0), .BAR_Y0(BY0), .BAR_H(BH),
        .PX_PER_BPM(PXB), .BAR_MAX_BPM(BMAX), .THRESH_BPM(THR)
    ) dut (
        .clk(clk), .reset(reset),
        .final_bpm_estimate(final_bpm_estimate), .overlay_en(overlay_en),
        .in_data(in_data), .in_startofpacket(in_sop), .in_endofpacket(in_eop),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_startofpacket(out_sop), .out_endofpacket(out_eop),
        .out_valid(out_valid), .out_ready(out_ready), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit rdy_rand = 1'b0;

    typedef struct { logic [29:0] d; logic s; logic e; int idx; } exp_t;
    exp_t exp_q[$];
    logic [29:0] cap [N];

    int m_idx = 0;
    int m_bpm = 0;
    bit m_en  = 1'b0;
    bit m_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [29:0] pix(input int f, input int idx);
        return 30'((f * 32'h0100_0000) ^ (idx * 37 + 5));
    endfunction

    function automatic logic [29:0] on_bar(input logic [29:0] c, input logic [29:0] d);
`ifdef VGA_BPM_BAR_BLEND_EN
        logic [29:0] r;
        for (int k = 0; k < 3; k++) r[10*k +: 10] = 10'(c[10*k +: 10] / 2) + 10'(d[10*k +: 10] / 2);
        return r;
`else
        return (d === d) ? c : c;
`endif
    endfunction

    // Expected pixel from raster index and the frame's latched BPM/enable.
    function automatic logic [29:0] model_pix(input logic [29:0] d, input int idx, input int bpm, input bit en);
        int x, y, len;
        x   = idx % W;
        y   = idx / W;
        len = ((bpm > BMAX) ? BMAX : bpm) * PXB;
        if (en && y >= BY0 && y < BY0 + BH && x >= BX0 && x < BX0 + len)
            return on_bar((bpm > THR) ? RED_L : GREEN_L, d);
        return d;
    endfunction

    // Per-cycle compare against the model; queue depth equals pipeline occupancy.
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_out_valid", {31'b0, out_valid}, 0);
            chk("reset_in_ready", {31'b0, in_ready}, 0);
            chk("reset_sync_err", {31'b0, sync_err}, 0);
            exp_q.delete();
            m_idx = 0; m_bpm = 0; m_en = 1'b0; m_err = 1'b0;
        end else begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
            chk("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
            chk("sync_err", {31'b0, sync_err}, {31'b0, m_err});
            if (out_valid && exp_q.size() > 0) begin
                chk("out_data", {2'b0, out_data}, {2'b0, exp_q[0].d});
                chk("out_sop_eop", {30'b0, out_sop, out_eop}, {30'b0, exp_q[0].s, exp_q[0].e});
                if (out_ready) begin
                    cap[exp_q[0].idx] = out_data;
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                exp_t t;
                bit last;
                if (in_sop) begin
                    if (m_idx != 0) m_err = 1'b1;
                    m_idx = 0;
                    m_bpm = int'(final_bpm_estimate);
                    m_en  = overlay_en;
                end
                last = (m_idx == N - 1);
                if (in_eop != last) m_err = 1'b1;
                t.d = model_pix(in_data, m_idx, m_bpm, m_en);
                t.s = in_sop; t.e = in_eop; t.idx = m_idx;
                exp_q.push_back(t);
                m_idx = (in_eop || last) ? 0 : m_idx + 1;
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            out_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [29:0] d, input logic s, input logic e);
        int g;
        g = 0;
        in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 1000) begin g++; @(negedge clk); end
        if (!in_ready) begin
            n_assert++; n_fail++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int f, input int nb, input int bpm0, input bit en0,
                              input int chg_at, input int bpm1, input bit en1,
                              input bit rnd, input int eop_at);
        final_bpm_estimate = 16'(bpm0);
        overlay_en = en0;
        for (int i = 0; i < nb; i++) begin
            if (i == chg_at) begin final_bpm_estimate = 16'(bpm1); overlay_en = en1; end
            if (rnd && $urandom_range(0, 4) == 0) begin in_valid = 1'b0; @(posedge clk); #1; end
            send(pix(f, i), i == 0, i == eop_at);
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        rdy_rand = 1'b0;
        while (exp_q.size() != 0 && g < 2000) begin g++; @(negedge clk); end
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic lit(input string nm, input int f, input int x, input int y,
                       input bit in_bar, input logic [29:0] c);
        logic [29:0] e;
        e = in_bar ? on_bar(c, pix(f, y * W + x)) : pix(f, y * W + x);
        chk(nm, {2'b0, cap[y * W + x]}, {2'b0, e});
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
        final_bpm_estimate = '0; overlay_en = 1'b0;
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_out_data", {2'b0, out_data}, 0);
        chk("post_rst_sop_eop", {30'b0, out_sop, out_eop}, 0);
        chk("post_rst_in_ready", {31'b0, in_ready}, 1);
        @(posedge clk); #1;

        // bpm 50: len 150, green x=20..169
        send_frame(1, N, 50, 1'b1, -1, 0, 1'b0, 1'b0, N - 1); drain();
        lit("A_x20_y8",   1, 20, 8, 1'b1, GREEN_L);
        lit("A_x169_y8",  1, 169, 8, 1'b1, GREEN_L);
        lit("A_x170_y8",  1, 170, 8, 1'b0, GREEN_L);
        lit("A_x19_y8",   1, 19, 8, 1'b0, GREEN_L);
        lit("A_x20_y7",   1, 20, 7, 1'b0, GREEN_L);
        lit("A_x100_y23", 1, 100, 23, 1'b1, GREEN_L);
        lit("A_x100_y24", 1, 100, 24, 1'b0, GREEN_L);

        // bpm 250 clamped to 60 -> 180 px red; mid-frame change to 50 ignored
        send_frame(2, N, 250, 1'b1, 100, 50, 1'b1, 1'b0, N - 1); drain();
        lit("B_x20_y8",   2, 20, 8, 1'b1, RED_L);
        lit("B_x199_y8",  2, 199, 8, 1'b1, RED_L);
        lit("B_x200_y8",  2, 200, 8, 1'b0, RED_L);
        lit("B_x199_y23", 2, 199, 23, 1'b1, RED_L);
        lit("B_x120_y15", 2, 120, 15, 1'b1, RED_L);

        // overlay off at sop, turned on mid-frame: whole frame passes through
        send_frame(3, N, 100, 1'b0, 10, 100, 1'b1, 1'b0, N - 1); drain();
        lit("C_x20_y8",   3, 20, 8, 1'b0, GREEN_L);
        lit("C_x100_y15", 3, 100, 15, 1'b0, GREEN_L);

        // random valid/ready; bpm 120 stays green, 121 turns red
        rdy_rand = 1'b1;
        send_frame(4, N, 120, 1'b1, -1, 0, 1'b0, 1'b1, N - 1); drain();
        lit("D_x199_y8",  4, 199, 8, 1'b1, GREEN_L);
        lit("D_x200_y8",  4, 200, 8, 1'b0, GREEN_L);
        rdy_rand = 1'b1;
        send_frame(5, N, 121, 1'b1, -1, 0, 1'b0, 1'b1, N - 1); drain();
        lit("E_x20_y8",   5, 20, 8, 1'b1, RED_L);
        lit("E_x199_y23", 5, 199, 23, 1'b1, RED_L);
        lit("E_x19_y23",  5, 19, 23, 1'b0, RED_L);

        // early eop at pixel index 1000, then a clean frame at bpm 30 (len 90)
        send_frame(6, 1001, 40, 1'b1, -1, 0, 1'b0, 1'b0, 1000); drain();
        chk("err_sync_set", {31'b0, sync_err}, 1);
        send_frame(7, N, 30, 1'b1, -1, 0, 1'b0, 1'b0, N - 1); drain();
        lit("F_x20_y8",   7, 20, 8, 1'b1, GREEN_L);
        lit("F_x109_y8",  7, 109, 8, 1'b1, GREEN_L);
        lit("F_x110_y8",  7, 110, 8, 1'b0, GREEN_L);
        chk("err_sync_held", {31'b0, sync_err}, 1);

        // reset mid-frame for 3 cycles, then a full frame at bpm 61 (clamped, green)
        send_frame(8, 300, 90, 1'b1, -1, 0, 1'b0, 1'b0, -1);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_out_valid", {31'b0, out_valid}, 0);
            chk("midrst_in_ready", {31'b0, in_ready}, 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("after_rst_sync_err", {31'b0, sync_err}, 0);
        @(posedge clk); #1;
        send_frame(9, N, 61, 1'b1, -1, 0, 1'b0, 1'b0, N - 1); drain();
        lit("G_x199_y8",  9, 199, 8, 1'b1, GREEN_L);
        lit("G_x200_y8",  9, 200, 8, 1'b0, GREEN_L);
        lit("G_x20_y24",  9, 20, 24, 1'b0, GREEN_L);
        chk("G_sync_err", {31'b0, sync_err}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
